mpaddsub_chunked: RTL and testbench

Parametrised multi-precision adder/subtractor that computes `in_a ± in_b` over `WIDTH` bits. It does this by streaming `CHUNK`-bit slices through a single carry-chained adder, one slice per clock. It is the configurable successor to the fixed 1027-bit, 129-bit-slice datapath adder, and it serves the modular-arithmetic datapath (Montgomery loop, final reduction). Compared with that adder it adds three things: parametrised width and slice size, a busy/ready handshake with back-to-back issue, and a sign-correct (WIDTH+1)-bit subtraction result.

---
 rtl/mpaddsub_chunked.sv | 118 +++++++++++
 tb/tb_mpaddsub_chunked.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mpaddsub_chunked.sv
// Multi-precision adder/subtractor: streams CHUNK-bit slices through one carry-chained adder,
// producing a sign-correct (WIDTH+1)-bit result NCHUNK+1 cycles after an accepted start.
module mpaddsub_chunked #(
   parameter int WIDTH = 1027,
   parameter int CHUNK = 129
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic             subtract,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic [WIDTH:0]   result,
   output logic             busy,
   output logic             done
);
   localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
   localparam int PW     = NCHUNK * CHUNK;
   localparam int CW     = $clog2(NCHUNK + 1);
   localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t          state_reg, state_next;
   logic [CW-1:0]   cnt_reg, cnt_next;
   logic            carry_reg, carry_next;
   logic            sub_reg, sub_next;
   logic [PW-1:0]   a_reg, a_next;
   logic [PW-1:0]   b_reg, b_next;
   logic [PW-1:0]   out_reg, out_next;
   logic [WIDTH:0]  result_next;
   logic            done_next;

   logic [CHUNK-1:0]    b_slice;
   logic [CHUNK:0]      sum;
   logic [PW+CHUNK-1:0] out_cat;
   logic [PW-1:0]       out_full;
   logic [WIDTH:0]      final_value;

   assign b_slice  = sub_reg ? ~b_reg[CHUNK-1:0] : b_reg[CHUNK-1:0];
   assign sum      = {1'b0, a_reg[CHUNK-1:0]} + {1'b0, b_slice} + {{CHUNK{1'b0}}, carry_reg};
   assign out_cat  = {sum[CHUNK-1:0], out_reg};
   assign out_full = PW'(out_cat >> CHUNK);

   // With padding, the inverted-B ones in the pad make bit WIDTH of the padded sum the sign/carry.
   // Without padding, the top bit is the final carry, inverted for subtraction.
   generate
      if (PW > WIDTH) begin : g_pad
         assign final_value = (WIDTH + 1)'(out_full);
      end else begin : g_nopad
         assign final_value = {sum[CHUNK] ^ sub_reg, out_full};
      end
   endgenerate

   assign busy = (state_reg == RUN);

   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      carry_next  = carry_reg;
      sub_next    = sub_reg;
      a_next      = a_reg;
      b_next      = b_reg;
      out_next    = out_reg;
      result_next = result;
      done_next   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               a_next     = PW'(in_a);
               b_next     = PW'(in_b);
               sub_next   = subtract;
               carry_next = subtract;
               out_next   = '0;
               cnt_next   = '0;
               state_next = RUN;
            end
         end
         RUN: begin
            out_next   = out_full;
            carry_next = sum[CHUNK];
            a_next     = a_reg >> CHUNK;
            b_next     = b_reg >> CHUNK;
            cnt_next   = cnt_reg + CW'(1);
            if (cnt_reg == LAST) begin
               result_next = final_value;
               done_next   = 1'b1;
               state_next  = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         carry_reg <= 1'b0;
         sub_reg   <= 1'b0;
         a_reg     <= '0;
         b_reg     <= '0;
         out_reg   <= '0;
         result    <= '0;
         done      <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         carry_reg <= carry_next;
         sub_reg   <= sub_next;
         a_reg     <= a_next;
         b_reg     <= b_next;
         out_reg   <= out_next;
         result    <= result_next;
         done      <= done_next;
      end
   end
endmodule

// File: tb/tb_mpaddsub_chunked.sv
// Directed checks at default parameters plus concurrent random sweeps over several (WIDTH, CHUNK) pairs.
module tb_mpaddsub_chunked;
   localparam int W = 1027;
   localparam int NOPS = 1000;

   logic clk = 1'b0;
   logic rst_n, sw_rstn;
   logic start, subtract, busy, done;
   logic [W-1:0] in_a, in_b;
   logic [W:0]   result;

   int n_checks = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   mpaddsub_chunked dut (
      .clk(clk), .resetn(rst_n), .start(start), .subtract(subtract),
      .in_a(in_a), .in_b(in_b), .result(result), .busy(busy), .done(done)
   );

   task automatic check(input string tag, input logic [1100:0] got, input logic [1100:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got hi=%0h lo=%0h, expected hi=%0h lo=%0h",
                    tag, got[1100:1024], got[127:0], exp[1100:1024], exp[127:0]);
   endtask

   function automatic logic [1026:0] rnd_wide();
      logic [1055:0] r;
      for (int k = 0; k < 33; k++) r = {r[1023:0], $urandom()};
      return r[1026:0];
   endfunction

   // Called #1 after an edge with the DUT idle (or in its done cycle); returns in the done cycle.
   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input logic [W:0] exp, input bit mid);
      int cyc;
      bit busy_ok;
      in_a = a; in_b = b; subtract = sub; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; cyc = 1; busy_ok = 1'b1;
      while (!done && cyc < 20) begin
         if (!busy) busy_ok = 1'b0;
         if (mid && cyc == 3) begin
            start = 1'b1; in_a = ~a; in_b = a; subtract = ~sub;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      $display("op %s: sub=%0b latency=%0d result_lo=%0h", tag, sub, cyc, result[63:0]);
      check({tag, "_busy_run"}, busy_ok, 1);
      check({tag, "_latency"}, cyc, 9);
      check({tag, "_result"}, result, exp);
      check({tag, "_busy_done"}, busy, 0);
   endtask

   genvar gi;
   generate
      for (gi = 0; gi < 5; gi++) begin : sw
         localparam int SW = (gi == 0) ? 1027 : (gi == 3) ? 100 : (gi == 4) ? 8 : 64;
         localparam int SC = (gi == 0) ? 129 : (gi == 1) ? 64 : (gi == 2) ? 16 : (gi == 3) ? 7 : 1;
         localparam int NC = (SW + SC - 1) / SC;
         logic st, sb, dn, by;
         logic fin = 1'b0;
         logic [SW-1:0] a, b;
         logic [SW:0]   res, exp;

         mpaddsub_chunked #(.WIDTH(SW), .CHUNK(SC)) u_dut (
            .clk(clk), .resetn(sw_rstn), .start(st), .subtract(sb),
            .in_a(a), .in_b(b), .result(res), .busy(by), .done(dn)
         );

         initial begin
            int cyc;
            st = 1'b0; sb = 1'b0; a = '0; b = '0;
            wait (sw_rstn === 1'b1);
            @(posedge clk); #1;
            for (int i = 0; i < NOPS; i++) begin
               a = SW'(rnd_wide());
               b = SW'(rnd_wide());
               case (i % 8)
                  0: b = a;
                  1: a = '0;
                  2: b = '0;
                  3: a = '1;
                  4: b = '1;
                  default: ;
               endcase
               sb = 1'($urandom());
               exp = sb ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
               st = 1'b1;
               @(posedge clk); #1;
               st = 1'b0; cyc = 1;
               a = SW'(rnd_wide()); b = SW'(rnd_wide()); sb = ~sb;
               while (!dn && cyc < NC + 6) begin
                  @(posedge clk); #1;
                  cyc++;
               end
               check($sformatf("sw%0d_op%0d_latency", gi, i), cyc, NC + 1);
               check($sformatf("sw%0d_op%0d_result", gi, i), res, exp);
            end
            $display("sweep WIDTH=%0d CHUNK=%0d: %0d ops issued", SW, SC, NOPS);
            fin = 1'b1;
         end
      end
   endgenerate

   initial begin
      logic [W:0] e;
      bit extra;
      rst_n = 1'b0; sw_rstn = 1'b0;
      start = 1'b0; subtract = 1'b0; in_a = '0; in_b = '0;
      #12;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_result", result, 0);
      @(posedge clk); #1;
      rst_n = 1'b1; sw_rstn = 1'b1;
      @(posedge clk); #1;

      // (2^W - 1) + 1 = 2^W
      e = '0; e[W] = 1'b1;
      run_op("add_max_plus_1", '1, {{(W-1){1'b0}}, 1'b1}, 1'b0, e, 1'b0);
      @(posedge clk); #1;
      check("done_one_cycle", done, 0);

      // 5 - 7 = -2 -> all ones except bit 0
      e = '1; e[0] = 1'b0;
      run_op("sub_5_7", W'(5), W'(7), 1'b1, e, 1'b0);
      check("sub_5_7_sign", result[W], 1);
      @(posedge clk); #1;
      run_op("sub_7_5", W'(7), W'(5), 1'b1, (W+1)'(2), 1'b0);
      check("sub_7_5_sign", result[W], 0);

      // Back-to-back: second start issued in the first op's done cycle
      @(posedge clk); #1;
      run_op("b2b_first", W'(100), W'(58), 1'b1, (W+1)'(42), 1'b0);
      e = '0; e[W] = 1'b1;
      run_op("b2b_second", {1'b1, {(W-1){1'b0}}}, {1'b1, {(W-1){1'b0}}}, 1'b0, e, 1'b0);

      // Start asserted mid-run must be ignored
      @(posedge clk); #1;
      run_op("mid_start", W'(1000), W'(1), 1'b0, (W+1)'(1001), 1'b1);
      extra = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (done || busy) extra = 1'b1;
      end
      check("mid_start_no_extra", extra, 0);

      // Reset in cycle 4 of an operation aborts it immediately
      in_a = W'(9); in_b = W'(2); subtract = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_result", result, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_op("after_reset_3p4", W'(3), W'(4), 1'b0, (W+1)'(7), 1'b0);

      for (int t = 0; t < 60000; t++) begin
         if (sw[0].fin && sw[1].fin && sw[2].fin && sw[3].fin && sw[4].fin) break;
         @(posedge clk);
      end
      check("sweep_finished", {sw[0].fin, sw[1].fin, sw[2].fin, sw[3].fin, sw[4].fin}, 5'b11111);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
